// File: rtl/semaforo_ctrl_if.sv
// semaforo_ctrl_if: groups the sensor/button inputs and the lamp/display
// outputs of the two-road traffic-light sequencer.
//   EN        run enable (0 freezes the controller)
//   CAR2      demand present on road 2
//   EMERG     emergency stop request (level)
//   S1, S2    light codes: 01 green, 10 orange, 11 red
//   SECS_LEFT remaining ticks in the current phase
//   PHASE_CHG one-cycle strobe on every state change
// master = environment (drives inputs), slave = controller.
interface semaforo_ctrl_if;
  logic       EN;
  logic       CAR2;
  logic       EMERG;
  logic [1:0] S1;
  logic [1:0] S2;
  logic [7:0] SECS_LEFT;
  logic       PHASE_CHG;

  modport master (
    output EN, CAR2, EMERG,
    input  S1, S2, SECS_LEFT, PHASE_CHG
  );

  modport slave (
    input  EN, CAR2, EMERG,
    output S1, S2, SECS_LEFT, PHASE_CHG
  );
endinterface

// File: rtl/semaforo_ctrl.sv
// semaforo_ctrl: two-road traffic-light sequencer
// G1 -> O1 -> AR_A -> G2 -> O2 -> AR_B -> G1, each phase timed in
// one-second ticks from a clock prescaler. Road 1 stays green while road 2
// has no demand; an emergency request forces green to orange and holds
// all-red until it clears.
// Ports:
//   CLK  system clock (rising edge)
//   RST  synchronous active-high reset
//   bus  semaforo_ctrl_if.slave (EN, CAR2, EMERG in; S1, S2, SECS_LEFT,
//        PHASE_CHG out, all outputs registered)
module semaforo_ctrl #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned T_GREEN   = 20,
  parameter int unsigned T_ORANGE  = 3,
  parameter int unsigned T_ALL_RED = 2
) (
  input  logic               CLK,
  input  logic               RST,
  semaforo_ctrl_if.slave     bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    LD_GREEN = T_GREEN[7:0];
  localparam logic [7:0]    LD_ORNG  = T_ORANGE[7:0];
  localparam logic [7:0]    LD_AR    = T_ALL_RED[7:0];

  localparam logic [1:0] L_GREEN  = 2'b01;
  localparam logic [1:0] L_ORANGE = 2'b10;
  localparam logic [1:0] L_RED    = 2'b11;

  typedef enum logic [2:0] {
    G1, O1, AR_A, G2, O2, AR_B
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    timer_q, timer_d;
  logic [PW-1:0] pre_q,   pre_d;
  logic          chg_q,   chg_d;
  logic [1:0]    s1_q,    s2_q;
  logic          tick;

  function automatic logic [3:0] lamps(input state_t s);
    case (s)
      G1:      lamps = {L_GREEN,  L_RED};
      O1:      lamps = {L_ORANGE, L_RED};
      G2:      lamps = {L_RED,    L_GREEN};
      O2:      lamps = {L_RED,    L_ORANGE};
      default: lamps = {L_RED,    L_RED};
    endcase
  endfunction

  function automatic state_t next_of(input state_t s);
    case (s)
      G1:      next_of = O1;
      O1:      next_of = AR_A;
      AR_A:    next_of = G2;
      G2:      next_of = O2;
      O2:      next_of = AR_B;
      default: next_of = G1;
    endcase
  endfunction

  function automatic logic [7:0] dur_of(input state_t s);
    case (s)
      G1, G2:  dur_of = LD_GREEN;
      O1, O2:  dur_of = LD_ORNG;
      default: dur_of = LD_AR;
    endcase
  endfunction

  assign tick = (pre_q == PRE_LAST) && bus.EN;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pre_d   = pre_q;
    chg_d   = chg_q;
    if (bus.EN) begin
      chg_d = 1'b0;
      pre_d = tick ? '0 : pre_q + PW'(1);
      // Emergency preempts green regardless of the prescaler, and also
      // wins over a green expiry in the same cycle.
      if (bus.EMERG && (state_q == G1 || state_q == G2)) begin
        state_d = (state_q == G1) ? O1 : O2;
        timer_d = LD_ORNG;
        pre_d   = '0;
        chg_d   = 1'b1;
      end else if (tick) begin
        if (timer_q > 8'd1) begin
          timer_d = timer_q - 8'd1;
        end else if (state_q == G1 && !bus.CAR2) begin
          timer_d = LD_GREEN;
        end else if ((state_q == AR_A || state_q == AR_B) && bus.EMERG) begin
          timer_d = LD_AR;
        end else begin
          state_d = next_of(state_q);
          timer_d = dur_of(next_of(state_q));
          chg_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= AR_B;
      timer_q <= LD_AR;
      pre_q   <= '0;
      chg_q   <= 1'b0;
      s1_q    <= L_RED;
      s2_q    <= L_RED;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pre_q        <= pre_d;
      chg_q        <= chg_d;
      {s1_q, s2_q} <= lamps(state_d);
    end
  end

  assign bus.S1        = s1_q;
  assign bus.S2        = s2_q;
  assign bus.SECS_LEFT = timer_q;
  assign bus.PHASE_CHG = chg_q;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Testbench for semaforo_ctrl (TICK_DIV=4, T_GREEN=5, T_ORANGE=2,
// T_ALL_RED=1). Expected phase entries are queued by the stimulus process;
// a monitor pops one on every PHASE_CHG strobe and compares cycle and lamps.
module tb_semaforo_ctrl;

  logic CLK;
  logic RST;
  semaforo_ctrl_if bus();

  semaforo_ctrl #(
    .TICK_DIV (4),
    .T_GREEN  (5),
    .T_ORANGE (2),
    .T_ALL_RED(1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    int         cyc;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [7:0] secs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;
  int   base   = 0;
  bit   sb_on  = 0;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) edges <= edges + 1;

  function automatic int now_cyc();
    return edges - base;
  endfunction

  // Scoreboard monitor: every PHASE_CHG must match the next queued entry.
  always @(negedge CLK) begin
    if (sb_on && !RST && bus.PHASE_CHG) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_phase_chg cyc=%0d got S1=%b S2=%b SECS=%0d expected no change",
                 now_cyc(), bus.S1, bus.S2, bus.SECS_LEFT);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != now_cyc() || e.s1 != bus.S1 || e.s2 != bus.S2 || e.secs != bus.SECS_LEFT) begin
          errors++;
          $display("FAIL phase_entry got cyc=%0d S1=%b S2=%b SECS=%0d expected cyc=%0d S1=%b S2=%b SECS=%0d",
                   now_cyc(), bus.S1, bus.S2, bus.SECS_LEFT, e.cyc, e.s1, e.s2, e.secs);
        end
      end
    end
  end

  task automatic push(input int c, input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] secs);
    exp_t e;
    e.cyc = c; e.s1 = s1; e.s2 = s2; e.secs = secs;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h expected %h", name, now_cyc(), got, exp);
    end
  endtask

  task automatic wait_to(input int n);
    while (now_cyc() < n) @(negedge CLK);
  endtask

  task automatic sb_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s pending_entries got %0d expected 0", name, sb.size());
    end
    sb.delete();
  endtask

  // Assert RST (caller at negedge), check the reset outputs, release so that
  // the following cycle is cycle 0.
  task automatic do_reset(input int cycles);
    RST = 1;
    repeat (cycles) @(negedge CLK);
    chk("reset_outputs", {bus.S1, bus.S2, bus.SECS_LEFT}, {2'b11, 2'b11, 8'd1});
    chk("reset_phase_chg", {11'd0, bus.PHASE_CHG}, 12'd0);
    base = edges;
    RST  = 0;
  endtask

  initial begin
    RST = 1; bus.EN = 1; bus.CAR2 = 1; bus.EMERG = 0;
    @(negedge CLK);

    // 1: full cycle
    do_reset(2);
    sb_on = 1;
    push(4, 2'b01, 2'b11, 5); push(24, 2'b10, 2'b11, 2); push(32, 2'b11, 2'b11, 1);
    push(36, 2'b11, 2'b01, 5); push(56, 2'b11, 2'b10, 2); push(64, 2'b11, 2'b11, 1);
    push(68, 2'b01, 2'b11, 5);
    wait_to(3);  chk("s1_ar_b_hold", {bus.S1, bus.S2, bus.SECS_LEFT}, {2'b11, 2'b11, 8'd1});
    wait_to(7);  chk("g1_secs_5", {4'd0, bus.SECS_LEFT}, 12'd5);
    wait_to(8);  chk("g1_secs_4", {4'd0, bus.SECS_LEFT}, 12'd4);
    wait_to(12); chk("g1_secs_3", {4'd0, bus.SECS_LEFT}, 12'd3);
    wait_to(16); chk("g1_secs_2", {4'd0, bus.SECS_LEFT}, 12'd2);
    wait_to(23); chk("g1_secs_1", {4'd0, bus.SECS_LEFT}, 12'd1);
    wait_to(70);
    sb_drained("full_cycle");

    // 2: demand hold
    bus.CAR2 = 0;
    do_reset(1);
    push(4, 2'b01, 2'b11, 5);
    wait_to(24); chk("hold_g1_reload", {bus.S1, bus.S2, bus.SECS_LEFT}, {2'b01, 2'b11, 8'd5});
    wait_to(30); bus.CAR2 = 1;
    push(44, 2'b10, 2'b11, 2);
    wait_to(43); chk("hold_g1_last", {bus.S1, bus.S2, bus.SECS_LEFT}, {2'b01, 2'b11, 8'd1});
    wait_to(46);
    sb_drained("demand_hold");

    // 3: emergency
    do_reset(1);
    push(4, 2'b01, 2'b11, 5); push(11, 2'b10, 2'b11, 2); push(19, 2'b11, 2'b11, 1);
    wait_to(10); bus.EMERG = 1;
    wait_to(27); chk("emerg_ar_held", {bus.S1, bus.S2, bus.SECS_LEFT}, {2'b11, 2'b11, 8'd1});
    wait_to(28); bus.EMERG = 0;
    push(31, 2'b11, 2'b01, 5);
    wait_to(33);
    sb_drained("emergency");

    // 4: enable freeze in G2
    do_reset(1);
    push(4, 2'b01, 2'b11, 5); push(24, 2'b10, 2'b11, 2); push(32, 2'b11, 2'b11, 1);
    push(36, 2'b11, 2'b01, 5); push(63, 2'b11, 2'b10, 2); push(71, 2'b11, 2'b11, 1);
    push(75, 2'b01, 2'b11, 5);
    wait_to(41); bus.EN = 0;
    wait_to(44); chk("freeze_outputs", {bus.S1, bus.S2, bus.SECS_LEFT}, {2'b11, 2'b01, 8'd4});
    wait_to(48); bus.EN = 1;
    wait_to(51); chk("after_freeze_secs", {4'd0, bus.SECS_LEFT}, 12'd3);
    wait_to(77);
    sb_drained("enable_freeze");

    // 5: reset during O2
    do_reset(1);
    push(4, 2'b01, 2'b11, 5); push(24, 2'b10, 2'b11, 2); push(32, 2'b11, 2'b11, 1);
    push(36, 2'b11, 2'b01, 5); push(56, 2'b11, 2'b10, 2);
    wait_to(58);
    sb_drained("pre_mid_reset");
    do_reset(1);
    push(4, 2'b01, 2'b11, 5); push(24, 2'b10, 2'b11, 2);
    wait_to(26);
    sb_drained("mid_reset_restart");

    // 6: random legality
    sb_on = 0;
    do_reset(1);
    begin
      int bad_code = 0, both_go = 0, bad_seq = 0;
      logic [1:0] p1, p2;
      p1 = bus.S1; p2 = bus.S2;
      for (int i = 0; i < 20000; i++) begin
        bus.EN    = ($urandom_range(0, 7) != 0);
        bus.CAR2  = ($urandom_range(0, 1) != 0);
        bus.EMERG = ($urandom_range(0, 15) == 0);
        @(negedge CLK);
        if (bus.S1 == 2'b00 || bus.S2 == 2'b00) bad_code++;
        if (bus.S1 != 2'b11 && bus.S2 != 2'b11) both_go++;
        if ((p1 == 2'b01 && bus.S1 != 2'b01 && bus.S1 != 2'b10) ||
            (p2 == 2'b01 && bus.S2 != 2'b01 && bus.S2 != 2'b10)) bad_seq++;
        p1 = bus.S1; p2 = bus.S2;
      end
      chk("rand_code_00", 12'(bad_code), 12'd0);
      chk("rand_both_nonred", 12'(both_go), 12'd0);
      chk("rand_green_to_orange", 12'(bad_seq), 12'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
